crop_downscale2x: RTL

Downstream stage of the crop block. It takes the cropped pixel stream (a W×H window per frame, `de` high only inside the window) and performs 2×2 box-averaging with rounding. The result is a (W/2)×(H/2) stream for the preview/encode path. One line buffer of horizontal pair-sums holds even-row data until the matching odd row arrives.

---
 rtl/vip_pkg.sv | 16 +
 rtl/crop_downscale2x_if.sv | 25 ++
 rtl/line_ram_sdp.sv | 21 ++
 rtl/crop_downscale2x.sv | 125 ++++++++++++
 4 files changed

// File: rtl/vip_pkg.sv
// Shared constants and helpers for the line-based video pipeline blocks.
package vip_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int COL_W = clog2(256 + 1);
  localparam int ROW_W = clog2(256 + 1);
  localparam int RND   = 2;

endpackage

// File: rtl/crop_downscale2x_if.sv
// Pixel-stream bundle between the crop stage and the 2x downscaler.
interface crop_downscale2x_if #(
  parameter int DW = 8
);
  logic          in_vs;
  logic          in_de;
  logic [DW-1:0] in_data;
  logic          out_vs;
  logic          out_de;
  logic [DW-1:0] out_data;
  logic          frame_done;
  logic          line_err;

  modport master (
    output in_vs, in_de, in_data,
    input  out_vs, out_de, out_data,
    input  frame_done, line_err
  );

  modport slave (
    input  in_vs, in_de, in_data,
    output out_vs, out_de, out_data,
    output frame_done, line_err
  );
endinterface

// File: rtl/line_ram_sdp.sv
// Simple dual-port line RAM: one write port, one registered read port.
module line_ram_sdp #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/crop_downscale2x.sv
// 2x2 box-average downscaler; even rows park pair-sums in a line
// buffer, odd rows combine them with their own pair-sums.
module crop_downscale2x
  import vip_pkg::*;
#(
  parameter int W  = 256,
  parameter int H  = 256,
  parameter int DW = 8
) (
  input  logic clk,
  input  logic rst_n,
  crop_downscale2x_if.slave vif
);
  localparam int CW = clog2(W + 1);
  localparam int RW = clog2(H + 1);
  localparam int AW = clog2(W / 2);
  localparam int SW = DW + 1;
  localparam int TW = DW + 2;
  localparam logic [CW-1:0] W_C = CW'(W);
  localparam logic [CW-1:0] WM1 = CW'(W - 1);
  localparam logic [RW-1:0] H_C = RW'(H);
  localparam logic [RW-1:0] HM1 = RW'(H - 1);

  logic          vs_q, de_q, armed_q, vs_d1_q;
  logic          out_vs_q, out_de_q, fd_q, err_q;
  logic [DW-1:0] hold_q, out_data_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic          vs_rise, line_end, take, in_win;
  logic          odd_row, odd_col, wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [SW-1:0] hsum, rd_data;
  logic [TW-1:0] total;
  logic [DW-1:0] avg;

  always_comb begin
    vs_rise  = vif.in_vs & ~vs_q;
    line_end = armed_q & de_q & ~vif.in_de;
    take     = armed_q & vif.in_de & ~vs_rise;
    in_win   = (row_q < H_C) && (col_q < W_C);
    odd_row  = row_q[0];
    odd_col  = col_q[0];
    wr_en    = take & in_win & ~odd_row & odd_col;
    rd_en    = take & in_win & odd_row & ~odd_col;
    addr     = col_q[AW:1];
    hsum     = {1'b0, hold_q} + {1'b0, vif.in_data};
    // 4*(2^DW-1)+2 still fits in DW+2 bits, so no saturation
    total    = {1'b0, rd_data} + {1'b0, hsum} + TW'(RND);
    avg      = DW'(total >> 2);
  end

  line_ram_sdp #(
    .DEPTH (W / 2),
    .AW    (AW),
    .WIDTH (SW)
  ) u_linebuf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (addr),
    .wdata_i (hsum),
    .re_i    (rd_en),
    .raddr_i (addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      armed_q    <= 1'b0;
      vs_d1_q    <= 1'b0;
      out_vs_q   <= 1'b0;
      out_de_q   <= 1'b0;
      fd_q       <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= '0;
      out_data_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      vs_q       <= vif.in_vs;
      de_q       <= vif.in_de & ~vs_rise;
      vs_d1_q    <= vif.in_vs;
      out_vs_q   <= vs_d1_q;
      out_de_q   <= 1'b0;
      out_data_q <= '0;
      fd_q       <= 1'b0;
      if (vs_rise) begin
        armed_q <= 1'b1;
        col_q   <= '0;
        row_q   <= '0;
        hold_q  <= '0;
        err_q   <= 1'b0;
      end else if (line_end) begin
        col_q <= '0;
        if (row_q == H_C) begin
          err_q <= 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
          if (col_q != W_C) err_q <= 1'b1;
        end
      end else if (take) begin
        if (!in_win) begin
          err_q <= 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
          if (!odd_col) begin
            hold_q <= vif.in_data;
          end else if (odd_row) begin
            out_de_q   <= 1'b1;
            out_data_q <= avg;
            fd_q       <= (row_q == HM1) && (col_q == WM1);
          end
        end
      end
    end
  end

  assign vif.out_vs     = out_vs_q;
  assign vif.out_de     = out_de_q;
  assign vif.out_data   = out_data_q;
  assign vif.frame_done = fd_q;
  assign vif.line_err   = err_q;
endmodule
